// File: rtl/reg_file_pkg.sv
// Shared definitions for the decode-stage register file: operand-routing modes
// and the width helper for flattened delay-line buses.
package reg_file_pkg;

   localparam logic [1:0] MODE_NORM = 2'b00;
   localparam logic [1:0] MODE_ONE  = 2'b01;
   localparam logic [1:0] MODE_SWAP = 2'b10;

   // Width of a flattened history bus holding 'depth' words of 'w' bits.
   function automatic int flatW(input int depth, input int w);
      return depth * w;
   endfunction

endpackage

// File: rtl/reg_file_bypass_if.sv
// Decode-side bus of the register file: read/write requests in, operands and
// their forwarding history out.
interface reg_file_bypass_if #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 3,
   parameter int BUF_DEPTH = 2
);
   import reg_file_pkg::*;

   logic                                  stall;
   logic [1:0]                            mode;
   logic [ADDR_W-1:0]                     raddr1;
   logic [ADDR_W-1:0]                     raddr2;
   logic                                  we;
   logic [ADDR_W-1:0]                     waddr;
   logic [DATA_W-1:0]                     wdata;
   logic [DATA_W-1:0]                     rdata1;
   logic [DATA_W-1:0]                     rdata2;
   logic [flatW(BUF_DEPTH, DATA_W)-1:0]   rdata1_dly;
   logic [flatW(BUF_DEPTH, DATA_W)-1:0]   rdata2_dly;
   logic [flatW(BUF_DEPTH, ADDR_W)-1:0]   raddr1_dly;
   logic [flatW(BUF_DEPTH, ADDR_W)-1:0]   raddr2_dly;

   modport master (
      output stall, mode, raddr1, raddr2, we, waddr, wdata,
      input  rdata1, rdata2, rdata1_dly, rdata2_dly, raddr1_dly, raddr2_dly
   );

   modport slave (
      input  stall, mode, raddr1, raddr2, we, waddr, wdata,
      output rdata1, rdata2, rdata1_dly, rdata2_dly, raddr1_dly, raddr2_dly
   );

endinterface

// File: rtl/pipe_delay.sv
// Generic shift register with synchronous reset and hold; stage 0 takes the
// input, stage k takes stage k-1. Output is all stages flattened, stage 0 in the LSBs.
module pipe_delay #(
   parameter int W     = 16,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_hold,
   input  logic [W-1:0]       i_d,
   output logic [DEPTH*W-1:0] o_q
);

   logic [W-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
      end else if (!i_hold) begin
         r_stage[0] <= i_d;
         for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
      end
   end

   always_comb begin
      o_q = '0;
      for (int k = 0; k < DEPTH; k++) o_q[k*W +: W] = r_stage[k];
   end

endmodule

// File: rtl/reg_file_bypass.sv
// 1W/2R register file with registered, write-first bypassed reads, operand
// routing modes and delay lines carrying operands/addresses for forwarding.
module reg_file_bypass
   import reg_file_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 3,
   parameter int BUF_DEPTH = 2,
   parameter int INIT_IDX  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   reg_file_bypass_if.slave       i_bus
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] r_rdata1;
   logic [DATA_W-1:0] r_rdata2;
   logic [DATA_W-1:0] w_v1;
   logic [DATA_W-1:0] w_v2;
   logic [DATA_W-1:0] w_next1;
   logic [DATA_W-1:0] w_next2;
   logic [BUF_DEPTH*DATA_W-1:0] w_rdata1_dly;
   logic [BUF_DEPTH*DATA_W-1:0] w_rdata2_dly;
   logic [BUF_DEPTH*ADDR_W-1:0] w_raddr1_dly;
   logic [BUF_DEPTH*ADDR_W-1:0] w_raddr2_dly;

   // Writes land even while stalled; a write presented during reset is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
      end else if (i_bus.we) begin
         r_regs[i_bus.waddr] <= i_bus.wdata;
      end
   end

   always_comb begin
      w_v1 = (i_bus.we && i_bus.waddr == i_bus.raddr1) ? i_bus.wdata : r_regs[i_bus.raddr1];
      w_v2 = (i_bus.we && i_bus.waddr == i_bus.raddr2) ? i_bus.wdata : r_regs[i_bus.raddr2];
   end

   always_comb begin
      w_next1 = w_v1;
      w_next2 = w_v2;
      case (i_bus.mode)
         MODE_ONE: begin
            w_next1 = w_v1;
            w_next2 = w_v1;
         end
         MODE_SWAP: begin
            w_next1 = w_v2;
            w_next2 = w_v1;
         end
         default: begin
            w_next1 = w_v1;
            w_next2 = w_v2;
         end
      endcase
   end

   // Held operands are not refreshed by a write during stall; the hazard unit covers that.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata1 <= '0;
         r_rdata2 <= '0;
      end else if (!i_bus.stall) begin
         r_rdata1 <= w_next1;
         r_rdata2 <= w_next2;
      end
   end

   pipe_delay #(.W(DATA_W), .DEPTH(BUF_DEPTH)) u_rdata1_dly (
      .clk(clk), .reset(reset), .i_hold(i_bus.stall), .i_d(r_rdata1), .o_q(w_rdata1_dly)
   );
   pipe_delay #(.W(DATA_W), .DEPTH(BUF_DEPTH)) u_rdata2_dly (
      .clk(clk), .reset(reset), .i_hold(i_bus.stall), .i_d(r_rdata2), .o_q(w_rdata2_dly)
   );
   pipe_delay #(.W(ADDR_W), .DEPTH(BUF_DEPTH)) u_raddr1_dly (
      .clk(clk), .reset(reset), .i_hold(i_bus.stall), .i_d(i_bus.raddr1), .o_q(w_raddr1_dly)
   );
   pipe_delay #(.W(ADDR_W), .DEPTH(BUF_DEPTH)) u_raddr2_dly (
      .clk(clk), .reset(reset), .i_hold(i_bus.stall), .i_d(i_bus.raddr2), .o_q(w_raddr2_dly)
   );

   assign i_bus.rdata1     = r_rdata1;
   assign i_bus.rdata2     = r_rdata2;
   assign i_bus.rdata1_dly = w_rdata1_dly;
   assign i_bus.rdata2_dly = w_rdata2_dly;
   assign i_bus.raddr1_dly = w_raddr1_dly;
   assign i_bus.raddr2_dly = w_raddr2_dly;

endmodule
